ram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single-port synchronous RAM between port A and port B. It accepts one command per cycle from the winning requester and drives the RAM's `wr_en`/`rd_en`/`address`/`data_in`. It never asserts read and write together, because the RAM gives read priority and would silently drop the write. It tracks the RAM's one-cycle read latency and steers the returned read-valid to the requester that issued the read.

---
 rtl/ram_port_arbiter_if.sv | 21 ++
 rtl/ram_port_arbiter.sv | 75 +++++++
 tb/tb_ram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side command/grant/read-return bundle for the two RAM ports.
interface ram_port_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int AW = 4
);
  logic             req_a, req_b;
  logic             we_a, we_b;
  logic [AW-1:0]    addr_a, addr_b;
  logic [WIDTH-1:0] wdata_a, wdata_b;
  logic             gnt_a, gnt_b;
  logic             rvalid_a, rvalid_b;
  logic [WIDTH-1:0] rdata;
  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata
  );
  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of a single-port synchronous RAM between ports A and B.
module ram_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    bus,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic [AW-1:0]        ram_addr,
  output logic [WIDTH-1:0]     ram_data_in,
  input  logic [WIDTH-1:0]     ram_data_out
);
  logic             gnt_a_q, gnt_b_q, wr_q, rd_q, rvalid_a_q, rvalid_b_q;
  logic             last_q, last_d, rd_pend_q, rd_pend_d, rd_own_q, rd_own_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             elig_a, elig_b, win_a, win_b, win, sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  // last_q/rd_own_q: 0 = port A, 1 = port B; a port granted last edge is masked this edge
  always_comb begin
    elig_a    = bus.req_a & ~gnt_a_q;
    elig_b    = bus.req_b & ~gnt_b_q;
    win_a     = elig_a & (~elig_b | last_q);
    win_b     = elig_b & ~win_a;
    win       = win_a | win_b;
    sel_we    = win_a ? bus.we_a : bus.we_b;
    sel_addr  = win_a ? bus.addr_a : bus.addr_b;
    sel_wdata = win_a ? bus.wdata_a : bus.wdata_b;
    last_d    = win ? win_b : last_q;
    addr_d    = win ? sel_addr : addr_q;
    din_d     = (win & sel_we) ? sel_wdata : din_q;
    rd_pend_d = win & ~sel_we;
    rd_own_d  = win_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      last_q     <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_own_q   <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      gnt_a_q    <= win_a;
      gnt_b_q    <= win_b;
      wr_q       <= win & sel_we;
      rd_q       <= rd_pend_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      rd_own_q   <= rd_own_d;
      rvalid_a_q <= rd_pend_q & ~rd_own_q;
      rvalid_b_q <= rd_pend_q & rd_own_q;
    end
  end
  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.rdata    = ram_data_out;
  assign ram_wr_en    = wr_q;
  assign ram_rd_en    = rd_q;
  assign ram_addr     = addr_q;
  assign ram_data_in  = din_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of the arbiter against a cycle-level reference model.
module tb_ram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ram_wr_en, ram_rd_en;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic [7:0] mem [16];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  // reference model state
  bit         m_ga = 0, m_gb = 0, m_last = 1, m_pa = 0, m_pb = 0, m_va = 0, m_vb = 0;
  logic [3:0] m_addr = '0;
  logic [7:0] m_din = '0, m_xa = '0, m_xb = '0;
  logic [7:0] sh [16];
  bit         sh_v [16];

  ram_port_arbiter_if #(.WIDTH(8), .AW(4)) bus ();

  ram_port_arbiter #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // single-port RAM, read priority, one-cycle registered read
  always_ff @(posedge clk) begin
    if (ram_rd_en) ram_data_out <= mem[ram_addr];
    else if (ram_wr_en) mem[ram_addr] <= ram_data_in;
  end

  task automatic tick();
    bit ea, eb, wa, wb, w, we;
    logic [3:0] ad, e_addr, e_st;
    logic [7:0] wd, e_din;
    logic [1:0] e_rv;
    ea = bus.req_a && !m_ga;
    eb = bus.req_b && !m_gb;
    wa = !rst && ea && (!eb || m_last);
    wb = !rst && eb && !wa;
    w  = wa || wb;
    we = wa ? bus.we_a : bus.we_b;
    ad = wa ? bus.addr_a : bus.addr_b;
    wd = wa ? bus.wdata_a : bus.wdata_b;
    e_st   = {wa, wb, w && we, w && !we};
    e_addr = rst ? 4'h0 : (w ? ad : m_addr);
    e_din  = rst ? 8'h00 : ((w && we) ? wd : m_din);
    e_rv   = rst ? 2'b00 : {m_pa, m_pb};
    @(posedge clk);
    #1;
    cyc++;
    n_cmp++;
    if ({bus.gnt_a, bus.gnt_b, ram_wr_en, ram_rd_en} !== e_st) begin
      n_bad++;
      $display("FAIL strobes cyc=%0d got gnt_a,gnt_b,wr,rd=%b exp=%b", cyc,
               {bus.gnt_a, bus.gnt_b, ram_wr_en, ram_rd_en}, e_st);
    end
    n_cmp++;
    if (ram_addr !== e_addr) begin
      n_bad++;
      $display("FAIL ram_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, e_addr);
    end
    n_cmp++;
    if (ram_data_in !== e_din) begin
      n_bad++;
      $display("FAIL ram_data_in cyc=%0d got=%h exp=%h", cyc, ram_data_in, e_din);
    end
    n_cmp++;
    if ({bus.rvalid_a, bus.rvalid_b} !== e_rv) begin
      n_bad++;
      $display("FAIL rvalid cyc=%0d got a,b=%b exp=%b", cyc, {bus.rvalid_a, bus.rvalid_b}, e_rv);
    end
    n_cmp++;
    if (ram_wr_en && ram_rd_en) begin
      n_bad++;
      $display("FAIL rd_wr_excl cyc=%0d got both strobes high exp at most one", cyc);
    end
    if (e_rv[1] && m_va) begin
      n_cmp++;
      if (bus.rdata !== m_xa) begin
        n_bad++;
        $display("FAIL rdata_a cyc=%0d got=%h exp=%h", cyc, bus.rdata, m_xa);
      end
    end
    if (e_rv[0] && m_vb) begin
      n_cmp++;
      if (bus.rdata !== m_xb) begin
        n_bad++;
        $display("FAIL rdata_b cyc=%0d got=%h exp=%h", cyc, bus.rdata, m_xb);
      end
    end
    m_ga   = wa;
    m_gb   = wb;
    m_last = rst ? 1'b1 : (w ? wb : m_last);
    m_addr = e_addr;
    m_din  = e_din;
    m_pa   = wa && !we;
    m_pb   = wb && !we;
    if (wa && !we) begin m_xa = sh[ad]; m_va = sh_v[ad]; end
    if (wb && !we) begin m_xb = sh[ad]; m_vb = sh_v[ad]; end
    if (w && we) begin sh[ad] = wd; sh_v[ad] = 1'b1; end
  endtask

  task automatic cmd(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d);
    bit got = 0;
    if (!p) begin bus.req_a = 1; bus.we_a = we; bus.addr_a = a; bus.wdata_a = d; end
    else begin bus.req_b = 1; bus.we_b = we; bus.addr_b = a; bus.wdata_b = d; end
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = p ? bus.gnt_b : bus.gnt_a;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL cmd_grant port=%0d got no grant exp grant within 6 cycles", p);
    end
    if (!p) bus.req_a = 0; else bus.req_b = 0;
  endtask

  task automatic test_reset();
    rst = 1; bus.req_a = 1; bus.req_b = 1;
    bus.we_a = 0; bus.we_b = 0; bus.addr_a = 4'h1; bus.addr_b = 4'h2;
    bus.wdata_a = 0; bus.wdata_b = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b, ram_wr_en, ram_rd_en, ram_addr, ram_data_in} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc=%0d got nonzero output exp all zero", cyc);
      end
    end
    rst = 0;
    tick();
    n_cmp++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_bad++;
      $display("FAIL first_grant got a,b=%b exp=10", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_a = 0; bus.req_b = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_write_read();
    cmd(0, 1, 4'h3, 8'h5A);
    cmd(0, 0, 4'h3, 8'h00);
    tick();
    n_cmp++;
    if ({bus.rvalid_a, bus.rvalid_b, bus.rdata} !== {2'b10, 8'h5A}) begin
      n_bad++;
      $display("FAIL write_read got rva,rvb=%b rdata=%h exp 10 5a", {bus.rvalid_a, bus.rvalid_b}, bus.rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    bit prev_a;
    cmd(1, 1, 4'h7, 8'h11);
    cmd(0, 1, 4'h2, 8'h22);
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 4'h2;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 4'h7;
    prev_a = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ((bus.gnt_a ^ bus.gnt_b) !== 1'b1 || bus.gnt_a === prev_a) begin
        n_bad++;
        $display("FAIL contention_alt cyc=%0d got a,b=%b exp a=%b", cyc, {bus.gnt_a, bus.gnt_b}, !prev_a);
      end
      prev_a = bus.gnt_a;
      if (i > 0) begin
        n_cmp++;
        if ((bus.rvalid_a ^ bus.rvalid_b) !== 1'b1 || bus.rdata !== (bus.rvalid_a ? 8'h22 : 8'h11)) begin
          n_bad++;
          $display("FAIL contention_rdata cyc=%0d got rva,rvb=%b rdata=%h", cyc, {bus.rvalid_a, bus.rvalid_b}, bus.rdata);
        end
      end
    end
    bus.req_a = 0; bus.req_b = 0;
    tick(); tick();
  endtask

  task automatic test_single_rate();
    int n = 0;
    bus.req_a = 1; bus.we_a = 0;
    for (int i = 0; i < 10; i++) begin
      bus.addr_a = 4'($urandom_range(0, 15));
      tick();
      if (bus.gnt_a) n++;
    end
    bus.req_a = 0;
    n_cmp++;
    if (n != 5) begin
      n_bad++;
      $display("FAIL single_rate got %0d grants exp 5", n);
    end
    tick(); tick();
  endtask

  task automatic test_forwarding();
    cmd(0, 1, 4'h9, 8'hC3);
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 4'h9;
    tick();
    bus.req_b = 0;
    n_cmp++;
    if (bus.gnt_b !== 1'b1) begin
      n_bad++;
      $display("FAIL fwd_grant got gnt_b=%b exp 1", bus.gnt_b);
    end
    tick();
    n_cmp++;
    if ({bus.rvalid_b, bus.rdata} !== {1'b1, 8'hC3}) begin
      n_bad++;
      $display("FAIL fwd_rdata got rvb=%b rdata=%h exp 1 c3", bus.rvalid_b, bus.rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    bit seen = 0;
    cmd(1, 1, 4'h4, 8'h00);
    tick();
    cmd(0, 0, 4'h4, 8'h00);
    rst = 1;
    tick();
    seen = seen | bus.rvalid_a;
    tick();
    seen = seen | bus.rvalid_a;
    rst = 0;
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 4'h1;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 4'h2;
    tick();
    seen = seen | bus.rvalid_a;
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL mid_reset_rvalid got rvalid_a=1 exp never");
    end
    n_cmp++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_reset_last got a,b=%b exp=10", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_a = 0; bus.req_b = 0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!bus.req_a || bus.gnt_a || $urandom_range(0, 9) == 0) begin
        bus.req_a   = ($urandom_range(0, 2) != 0);
        bus.we_a    = $urandom_range(0, 1) == 1;
        bus.addr_a  = 4'($urandom_range(0, 15));
        bus.wdata_a = 8'($urandom);
      end
      if (!bus.req_b || bus.gnt_b || $urandom_range(0, 9) == 0) begin
        bus.req_b   = ($urandom_range(0, 2) != 0);
        bus.we_b    = $urandom_range(0, 1) == 1;
        bus.addr_b  = 4'($urandom_range(0, 15));
        bus.wdata_b = 8'($urandom);
      end
      tick();
    end
    bus.req_a = 0; bus.req_b = 0;
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin sh[i] = '0; sh_v[i] = 0; end
    test_reset();
    test_write_read();
    test_contention();
    test_single_rate();
    test_forwarding();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
